sci_piso_tx_arbiter: RTL and testbench

Round-robin transmit scheduler that shares one internal PISO serializer between NREQ requesters in the SCI serial path. It accepts parallel words over per-requester REQ/ACK handshakes and drives the serializer's load/shift controls. Each granted word is emitted LSB-first on a single serial line with a programmable bit period and valid/last strobes.

---
 rtl/sci_piso_tx_arbiter_if.sv | 24 ++
 rtl/sci_piso_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sci_piso_tx_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sci_piso_tx_arbiter_if.sv
// Handshake and serial-line bundle for sci_piso_tx_arbiter.
// master: the requester side (drives REQ/DATA); slave: the arbiter.
interface sci_piso_tx_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 8
);
    logic [NREQ-1:0]       REQ;
    logic [NREQ*DEPTH-1:0] DATA;
    logic [NREQ-1:0]       ACK;
    logic                  BUSY;
    logic                  SOUT;
    logic                  SVALID;
    logic                  SLAST;

    modport master (
        output REQ, DATA,
        input  ACK, BUSY, SOUT, SVALID, SLAST
    );

    modport slave (
        input  REQ, DATA,
        output ACK, BUSY, SOUT, SVALID, SLAST
    );
endinterface

// File: rtl/sci_piso_tx_arbiter.sv
// sci_piso_tx_arbiter: round-robin scheduler sharing one PISO serializer
// between NREQ requesters. Words go out LSB-first, each bit held CLK_DIV
// cycles, framed by SVALID and SLAST.
// Optional feature: define SCI_TX_PARITY_EN to append an even-parity bit
// (PAR state) after the data bits; SLAST then marks the parity bit.
// All outputs are registered; nothing combinational reaches them from REQ/DATA.
module sci_piso_tx_arbiter #(
    parameter int DEPTH   = 8,
    parameter int NREQ    = 2,
    parameter int CLK_DIV = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    sci_piso_tx_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] PEN_BIT  = CNT_W'(DEPTH - 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef SCI_TX_PARITY_EN
        PAR,
`endif
        GAP
    } state_t;

    state_t             state_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   grant_reg;
    logic [DEPTH-1:0]   shreg_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [DIV_W-1:0]   div_reg;
    logic [NREQ-1:0]    ack_reg;
    logic               busy_reg;
    logic               sout_reg;
    logic               svalid_reg;
    logic               slast_reg;
`ifdef SCI_TX_PARITY_EN
    logic               par_reg;
`endif

    logic [PTR_W-1:0]   grant_next;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   scan_idx;
    logic               found;

    // Per-requester view of the flat DATA bus
    logic [DEPTH-1:0]   data_word [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign data_word[gi] = bus.DATA[gi*DEPTH +: DEPTH];
        end
    endgenerate

    // Pick the first requester at or after the priority pointer, wrapping
    always_comb begin
        grant_next = '0;
        scan_idx   = '0;
        found      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PTR_W'((int'(ptr_reg) + k) % NREQ);
            if (!found && bus.REQ[scan_idx]) begin
                found      = 1'b1;
                grant_next = scan_idx;
            end
        end
        ptr_next = PTR_W'((int'(grant_reg) + 1) % NREQ);
    end

    // Frame sequencer: state, serializer, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            bit_cnt_reg <= '0;
            div_reg     <= '0;
            ack_reg     <= '0;
            busy_reg    <= 1'b0;
            sout_reg    <= 1'b0;
            svalid_reg  <= 1'b0;
            slast_reg   <= 1'b0;
`ifdef SCI_TX_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        state_reg           <= LOAD;
                        grant_reg           <= grant_next;
                        ack_reg             <= '0;
                        ack_reg[grant_next] <= 1'b1;
                        busy_reg            <= 1'b1;
                    end
                end
                LOAD: begin
                    state_reg   <= SHIFT;
                    shreg_reg   <= data_word[grant_reg];
                    ptr_reg     <= ptr_next;
                    bit_cnt_reg <= '0;
                    div_reg     <= '0;
                    ack_reg     <= '0;
                    sout_reg    <= data_word[grant_reg][0];
                    svalid_reg  <= 1'b1;
                    slast_reg   <= 1'b0;
`ifdef SCI_TX_PARITY_EN
                    par_reg     <= ^data_word[grant_reg];
`endif
                end
                SHIFT: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg     <= '0;
                        shreg_reg   <= shreg_reg >> 1;
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
`ifdef SCI_TX_PARITY_EN
                            state_reg  <= PAR;
                            sout_reg   <= par_reg;
                            slast_reg  <= 1'b1;
`else
                            state_reg  <= GAP;
                            sout_reg   <= 1'b0;
                            svalid_reg <= 1'b0;
                            slast_reg  <= 1'b0;
`endif
                        end else begin
                            sout_reg  <= shreg_reg[1];
`ifdef SCI_TX_PARITY_EN
                            slast_reg <= 1'b0;
`else
                            slast_reg <= (bit_cnt_reg == PEN_BIT);
`endif
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
`ifdef SCI_TX_PARITY_EN
                PAR: begin
                    if (div_reg == DIV_LAST) begin
                        state_reg  <= GAP;
                        div_reg    <= '0;
                        sout_reg   <= 1'b0;
                        svalid_reg <= 1'b0;
                        slast_reg  <= 1'b0;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
`endif
                GAP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ACK    = ack_reg;
    assign bus.BUSY   = busy_reg;
    assign bus.SOUT   = sout_reg;
    assign bus.SVALID = svalid_reg;
    assign bus.SLAST  = slast_reg;

endmodule

// File: tb/tb_sci_piso_tx_arbiter.sv
// Directed bench for sci_piso_tx_arbiter: instance a (CLK_DIV=2) for framing,
// pending requests, reset and parity; instance b (CLK_DIV=1) for round-robin
// spacing. Honours SCI_TX_PARITY_EN when defined at compile time.
module tb_sci_piso_tx_arbiter;
    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    sci_piso_tx_arbiter_if #(.NREQ(2), .DEPTH(8)) bus_a ();
    sci_piso_tx_arbiter_if #(.NREQ(2), .DEPTH(8)) bus_b ();

    sci_piso_tx_arbiter #(.DEPTH(8), .NREQ(2), .CLK_DIV(2)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    sci_piso_tx_arbiter #(.DEPTH(8), .NREQ(2), .CLK_DIV(1)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef SCI_TX_PARITY_EN
    localparam int EXP_SPACING = 12;
`else
    localparam int EXP_SPACING = 11;
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the first SHIFT cycle of instance a; returns in the first IDLE cycle.
    // REQ is driven to on_v at data cycle inj_at and to off_v one cycle later.
    task automatic check_frame(input logic [7:0] d, input logic pexp, input string tag,
                               input int inj_at, input logic [1:0] on_v, input logic [1:0] off_v);
        logic el;
        for (int i = 0; i < 16; i++) begin
`ifdef SCI_TX_PARITY_EN
            el = 1'b0;
`else
            el = (i >= 14);
`endif
            chk({tag, "_sout"},   32'(bus_a.SOUT),   32'(d[i/2]));
            chk({tag, "_svalid"}, 32'(bus_a.SVALID), 32'd1);
            chk({tag, "_slast"},  32'(bus_a.SLAST),  32'(el));
            chk({tag, "_ack"},    32'(bus_a.ACK),    32'd0);
            chk({tag, "_busy"},   32'(bus_a.BUSY),   32'd1);
            if (i == inj_at)     bus_a.REQ = on_v;
            if (i == inj_at + 1) bus_a.REQ = off_v;
            tick();
        end
`ifdef SCI_TX_PARITY_EN
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_par"},        32'(bus_a.SOUT),   32'(pexp));
            chk({tag, "_par_svalid"}, 32'(bus_a.SVALID), 32'd1);
            chk({tag, "_par_slast"},  32'(bus_a.SLAST),  32'd1);
            tick();
        end
`endif
        chk({tag, "_gap"},      32'({bus_a.SVALID, bus_a.SOUT, bus_a.SLAST}), 32'd0);
        chk({tag, "_gap_busy"}, 32'(bus_a.BUSY), 32'd1);
        chk({tag, "_gap_ack"},  32'(bus_a.ACK),  32'd0);
        tick();
        chk({tag, "_idle_busy"}, 32'(bus_a.BUSY), 32'd0);
        chk({tag, "_idle_ack"},  32'(bus_a.ACK),  32'd0);
        $display("frame %s data=%02h parity_exp=%0b checked (errors so far %0d)", tag, d, pexp, errors);
    endtask

    initial begin
        int          n;
        int          ack_cyc [4];
        logic [1:0]  ack_val [4];
        logic [1:0]  exp_seq [4];

        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        bus_a.REQ  = '0;
        bus_a.DATA = '0;
        bus_b.REQ  = '0;
        bus_b.DATA = '0;
        RST = 1'b1;
        repeat (3) tick();
        chk("reset_a", 32'({bus_a.ACK, bus_a.BUSY, bus_a.SOUT, bus_a.SVALID, bus_a.SLAST}), 32'd0);
        chk("reset_b", 32'({bus_b.ACK, bus_b.BUSY, bus_b.SOUT, bus_b.SVALID, bus_b.SLAST}), 32'd0);
        RST = 1'b0;
        tick();
        chk("idle_a", 32'({bus_a.ACK, bus_a.BUSY, bus_a.SVALID}), 32'd0);

        // Single frame 0xA5 from requester 0
        bus_a.DATA[7:0] = 8'hA5;
        bus_a.REQ = 2'b01;
        tick();
        chk("t1_ack",    32'(bus_a.ACK),    32'b01);
        chk("t1_busy",   32'(bus_a.BUSY),   32'd1);
        chk("t1_svalid", 32'(bus_a.SVALID), 32'd0);
        bus_a.REQ = 2'b00;
        tick();
        check_frame(8'hA5, 1'b0, "t1", -1, 2'b00, 2'b00);

        // Requester 1 raises REQ mid-frame of requester 0; it must pend
        bus_a.DATA[15:8] = 8'h01;
        bus_a.REQ = 2'b01;
        tick();
        chk("t3_ack0", 32'(bus_a.ACK), 32'b01);
        bus_a.REQ = 2'b00;
        tick();
        check_frame(8'hA5, 1'b0, "t3a", 3, 2'b10, 2'b10);
        tick();
        chk("t3_ack1", 32'(bus_a.ACK), 32'b10);
        bus_a.REQ = 2'b00;
        tick();
        // Requester 0 pulses REQ for one cycle mid-frame: never granted
        check_frame(8'h01, 1'b1, "t6", 5, 2'b01, 2'b00);
        for (int i = 0; i < 4; i++) begin
            chk("t6_noack", 32'(bus_a.ACK),  32'd0);
            chk("t6_busy",  32'(bus_a.BUSY), 32'd0);
            tick();
        end

        // Reset during data bit 3 of a requester-0 frame, REQ=11 held
        bus_a.REQ = 2'b11;
        tick();
        chk("t4_ack_pre", 32'(bus_a.ACK), 32'b01);
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk("t4_bit3_svalid", 32'(bus_a.SVALID), 32'd1);
        chk("t4_bit3_sout",   32'(bus_a.SOUT),   32'd0);
        RST = 1'b1;
        tick();
        chk("t4_reset", 32'({bus_a.ACK, bus_a.BUSY, bus_a.SOUT, bus_a.SVALID, bus_a.SLAST}), 32'd0);
        RST = 1'b0;
        tick();
        chk("t4_ack_post", 32'(bus_a.ACK), 32'b01);
        bus_a.REQ = 2'b00;
        tick();
        check_frame(8'hA5, 1'b0, "t4", -1, 2'b00, 2'b00);

        // Round robin on instance b, CLK_DIV=1, both requesters held high
        bus_b.DATA = 16'hF00F;
        bus_b.REQ  = 2'b11;
        n = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (bus_b.ACK != 2'b00 && n < 4) begin
                ack_cyc[n] = c;
                ack_val[n] = bus_b.ACK;
                n++;
            end
        end
        bus_b.REQ = 2'b00;
        chk("t2_ack_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                chk("t2_ack_val", 32'(ack_val[k]), 32'(exp_seq[k]));
                if (k > 0) chk("t2_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'(EXP_SPACING));
            end
        end
        chk("t2_first_ack_cycle", 32'(ack_cyc[0]), 32'd1);
        $display("round robin: %0d grants recorded, spacing expected %0d", n, EXP_SPACING);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
